// File: rtl/light_pkg.sv
// Shared types and constants for the light-sensor ADC path.
// Used by the sequencer, its SPI receiver and the downstream comparator/counter.
package light_pkg;

   localparam int ADC_W = 8;

   // Comparator thresholds for the light intensity counter
   localparam logic [ADC_W-1:0] LIGHT_HI = 8'h50;
   localparam logic [ADC_W-1:0] LIGHT_LO = 8'h10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2,
      WAIT = 2'd3
   } state_e;

   // Mean of four samples from their 10-bit sum (truncating)
   function automatic logic [ADC_W-1:0] avg4(input logic [ADC_W+1:0] sum);
      return sum[ADC_W+1:2];
   endfunction

endpackage

// File: rtl/spi_rx_shift.sv
// SPI-style receiver: half-period timer, sclk generation, bit counter and
// shift register. A one-cycle start runs exactly NBITS bits; done is high in
// the last cycle of the final high phase. Data is sampled on the clk edge
// that drives sclk 0->1.
module spi_rx_shift #(
   parameter int unsigned NBITS   = 11,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned DATA_W  = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              miso,
   output logic              sclk,
   output logic [DATA_W-1:0] data,
   output logic              done
);

   localparam int HW = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);
   localparam logic [3:0]    BLAST = 4'(NBITS - 1);

   logic              active_q, active_d;
   logic              sclk_q, sclk_d;
   logic [HW-1:0]     hcnt_q, hcnt_d;
   logic [3:0]        bcnt_q, bcnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;

   logic half_end, rise, fall;

   assign half_end = active_q && (hcnt_q == HLAST);
   assign rise     = half_end && !sclk_q;
   assign fall     = half_end && sclk_q;
   assign done     = fall && (bcnt_q == BLAST);

   assign sclk = sclk_q;
   assign data = sh_q;

   // Next-state for timer, sclk, bit counter and shift register
   always_comb begin
      active_d = active_q;
      sclk_d   = sclk_q;
      hcnt_d   = hcnt_q;
      bcnt_d   = bcnt_q;
      sh_d     = sh_q;
      if (start) begin
         active_d = 1'b1;
         sclk_d   = 1'b0;
         hcnt_d   = '0;
         bcnt_d   = '0;
         sh_d     = '0;
      end else if (active_q) begin
         hcnt_d = half_end ? '0 : hcnt_q + HW'(1);
         if (half_end) sclk_d = ~sclk_q;
         // Leading dummy bits shift straight through and fall off the top,
         // leaving only the last DATA_W bits once the frame is complete.
         if (rise) sh_d = {sh_q[DATA_W-2:0], miso};
         if (fall) bcnt_d = bcnt_q + 4'd1;
         if (done) begin
            active_d = 1'b0;
            bcnt_d   = '0;
         end
      end
   end

   // Receiver state registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         active_q <= 1'b0;
         sclk_q   <= 1'b0;
         hcnt_q   <= '0;
         bcnt_q   <= '0;
         sh_q     <= '0;
      end else begin
         active_q <= active_d;
         sclk_q   <= sclk_d;
         hcnt_q   <= hcnt_d;
         bcnt_q   <= bcnt_d;
         sh_q     <= sh_d;
      end
   end

endmodule

// File: rtl/light_adc_seq.sv
// Light-sensor ADC sequencer: periodically runs a conversion, presents the
// result on adc_data and strobes sig once per fresh sample.
// Optional LIGHT_ADC_SEQ_AVG_EN: report the mean of every 4 conversions.
module light_adc_seq
   import light_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 4,
   parameter int unsigned SAMPLE_PERIOD = 50000,
   parameter int unsigned LEAD_BITS     = 3
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             trig,
   input  logic             adc_miso,
   output logic             adc_cs_n,
   output logic             adc_sclk,
   output logic [ADC_W-1:0] adc_data,
   output logic             sig,
   output logic             busy
);

   localparam int unsigned NBITS = LEAD_BITS + ADC_W;
   localparam int PW = $clog2(SAMPLE_PERIOD + 1);
   localparam logic [PW-1:0] PLAST = PW'(SAMPLE_PERIOD - 1);

   state_e           state_q, state_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [ADC_W-1:0] data_q, data_d;
   logic             sig_q, sig_d;

   logic             rx_start, rx_done;
   logic [ADC_W-1:0] rx_data;

   // Kick the receiver on every entry into CONV
   assign rx_start = (state_q != CONV) && (state_d == CONV);

   spi_rx_shift #(
      .NBITS  (NBITS),
      .CLK_DIV(CLK_DIV),
      .DATA_W (ADC_W)
   ) u_rx (
      .clk  (clk),
      .n_rst(n_rst),
      .start(rx_start),
      .miso (adc_miso),
      .sclk (adc_sclk),
      .data (rx_data),
      .done (rx_done)
   );

   assign adc_cs_n = (state_q != CONV);
   assign busy     = (state_q == CONV) || (state_q == DONE);
   assign adc_data = data_q;
   assign sig      = sig_q;

   // Sequencer next-state and sample-period timer
   always_comb begin
      state_d = state_q;
      pcnt_d  = '0;
      unique case (state_q)
         IDLE: if (en) state_d = CONV;
         // Conversions always run to completion regardless of en/trig
         CONV: if (rx_done) state_d = DONE;
         DONE: state_d = en ? WAIT : IDLE;
         WAIT: begin
            if (!en)                          state_d = IDLE;
            else if (trig || pcnt_q == PLAST) state_d = CONV;
            else                              pcnt_d  = pcnt_q + PW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef LIGHT_ADC_SEQ_AVG_EN
   logic [ADC_W+1:0] acc_q, acc_d;
   logic [1:0]       idx_q, idx_d;
   logic [ADC_W+1:0] sum;

   assign sum = acc_q + {2'b00, rx_data};

   // Accumulate four conversions; publish their mean on the fourth
   always_comb begin
      acc_d  = acc_q;
      idx_d  = idx_q;
      data_d = data_q;
      sig_d  = 1'b0;
      if ((state_d == IDLE) && (state_q != IDLE)) begin
         acc_d = '0;
         idx_d = '0;
      end else if (rx_done) begin
         if (idx_q == 2'd3) begin
            data_d = avg4(sum);
            sig_d  = 1'b1;
            acc_d  = '0;
            idx_d  = '0;
         end else begin
            acc_d = sum;
            idx_d = idx_q + 2'd1;
         end
      end
   end

   // Averaging state registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end
`else
   // Every finished conversion is published; sig lands in the DONE cycle
   always_comb begin
      data_d = data_q;
      sig_d  = 1'b0;
      if (rx_done) begin
         data_d = rx_data;
         sig_d  = 1'b1;
      end
   end
`endif

   // Sequencer state and output registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         pcnt_q  <= '0;
         data_q  <= '0;
         sig_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         data_q  <= data_d;
         sig_q   <= sig_d;
      end
   end

endmodule

// File: tb/tb_light_adc_seq.sv
// Directed bench for light_adc_seq (CLK_DIV=2, SAMPLE_PERIOD=20, LEAD_BITS=3).
// Build with LIGHT_ADC_SEQ_AVG_EN to exercise the 4-sample averaging mode.
module tb_light_adc_seq;
   import light_pkg::*;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       en = 1'b0;
   logic       trig = 1'b0;
   logic       adc_miso;
   logic       adc_cs_n, adc_sclk, sig, busy;
   logic [7:0] adc_data;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int cs_low_cnt = 0;
   int rise_cnt = 0;
   int sig_cnt = 0;
   logic sclk_prev = 1'b0;

   // ADC model: 3 leading dummy bits (nonzero, must be discarded) then data
   logic [7:0]  adc_val = 8'h00;
   logic [10:0] frame;
   int          bidx = 0;

   always #5 clk = ~clk;

   light_adc_seq #(
      .CLK_DIV      (2),
      .SAMPLE_PERIOD(20),
      .LEAD_BITS    (3)
   ) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .en      (en),
      .trig    (trig),
      .adc_miso(adc_miso),
      .adc_cs_n(adc_cs_n),
      .adc_sclk(adc_sclk),
      .adc_data(adc_data),
      .sig     (sig),
      .busy    (busy)
   );

   assign frame    = {3'b101, adc_val};
   assign adc_miso = (bidx < 11) ? frame[10-bidx] : 1'b0;

   always @(negedge adc_cs_n) bidx = 0;
   always @(negedge adc_sclk) if (!adc_cs_n) bidx = bidx + 1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!adc_cs_n) cs_low_cnt++;
      if (adc_sclk && !sclk_prev) rise_cnt++;
      sclk_prev = adc_sclk;
      if (sig) sig_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_sig(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         #1;
         if (sig) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_cs(input logic lvl, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         #1;
         if (adc_cs_n === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int cs_base, rise_base, sig_base, t_sig, t_prev, cnt_hits;

      #2 n_rst = 1'b0;
      step(3);
      chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
      chk("rst_sclk", 32'(adc_sclk), 32'd0);
      chk("rst_data", 32'(adc_data), 32'h00);
      chk("rst_sig",  32'(sig),      32'd0);
      chk("rst_busy", 32'(busy),     32'd0);

`ifndef LIGHT_ADC_SEQ_AVG_EN
      // First conversion straight out of reset
      adc_val   = 8'hA5;
      en        = 1'b1;
      cs_base   = cs_low_cnt;
      rise_base = rise_cnt;
      n_rst     = 1'b1;
      wait_sig(80, ok);
      chk("t1_sig_to", 32'(ok), 32'd1);
      chk("t1_data",   32'(adc_data), 32'hA5);
      chk("t1_cs_low", 32'(cs_low_cnt - cs_base), 32'd44);
      chk("t1_rises",  32'(rise_cnt - rise_base), 32'd11);
      t_prev  = cyc;
      adc_val = 8'h60;
      step(1);
      chk("t1_sig_1cyc", 32'(sig),  32'd0);
      chk("t1_busy",     32'(busy), 32'd0);

      // Free run: three samples, 65 clks apart
      cnt_hits = 0;
      wait_sig(100, ok);
      chk("t2a_sig_to", 32'(ok), 32'd1);
      chk("t2a_data",   32'(adc_data), 32'h60);
      chk("t2a_period", 32'(cyc - t_prev), 32'd65);
      if (adc_data >= LIGHT_HI || adc_data <= LIGHT_LO) cnt_hits++;
      t_prev  = cyc;
      adc_val = 8'h08;
      step(30);
      chk("t2a_hold", 32'(adc_data), 32'h60);
      wait_sig(100, ok);
      chk("t2b_sig_to", 32'(ok), 32'd1);
      chk("t2b_data",   32'(adc_data), 32'h08);
      chk("t2b_period", 32'(cyc - t_prev), 32'd65);
      if (adc_data >= LIGHT_HI || adc_data <= LIGHT_LO) cnt_hits++;
      t_prev  = cyc;
      adc_val = 8'h30;
      step(30);
      chk("t2b_hold", 32'(adc_data), 32'h08);
      wait_sig(100, ok);
      chk("t2c_sig_to", 32'(ok), 32'd1);
      chk("t2c_data",   32'(adc_data), 32'h30);
      chk("t2c_period", 32'(cyc - t_prev), 32'd65);
      if (adc_data >= LIGHT_HI || adc_data <= LIGHT_LO) cnt_hits++;
      chk("t2_counter", 32'(cnt_hits), 32'd2);

      // en dropped mid-conversion: it still completes
      adc_val = 8'h3C;
      cs_base = cs_low_cnt;
      wait_cs(1'b0, 40, ok);
      chk("t3_cs_to", 32'(ok), 32'd1);
      step(10);
      en = 1'b0;
      wait_sig(60, ok);
      chk("t3_sig_to", 32'(ok), 32'd1);
      chk("t3_data",   32'(adc_data), 32'h3C);
      chk("t3_cs_low", 32'(cs_low_cnt - cs_base), 32'd44);
      step(1);
      chk("t3_busy", 32'(busy), 32'd0);
      cs_base  = cs_low_cnt;
      sig_base = sig_cnt;
      step(100);
      chk("t3_idle_cs",  32'(cs_low_cnt - cs_base), 32'd0);
      chk("t3_idle_sig", 32'(sig_cnt - sig_base), 32'd0);
      chk("t3_idle_data", 32'(adc_data), 32'h3C);

      // trig in WAIT cuts the period short; trig in CONV is ignored
      adc_val = 8'h11;
      en      = 1'b1;
      wait_sig(80, ok);
      chk("t4a_sig_to", 32'(ok), 32'd1);
      chk("t4a_data",   32'(adc_data), 32'h11);
      t_sig   = cyc;
      adc_val = 8'h99;
      step(6);
      chk("t4_wait_cs", 32'(adc_cs_n), 32'd1);
      trig = 1'b1;
      step(1);
      trig = 1'b0;
      chk("t4_trig_cs", 32'(adc_cs_n), 32'd0);
      chk("t4_trig_lat", 32'(cyc - t_sig), 32'd7);
      step(5);
      trig = 1'b1;
      step(1);
      trig = 1'b0;
      wait_sig(60, ok);
      chk("t4b_sig_to", 32'(ok), 32'd1);
      chk("t4b_data",   32'(adc_data), 32'h99);
      adc_val = 8'hC6;
      cs_base = cs_low_cnt;
      step(15);
      chk("t4_no_extra", 32'(cs_low_cnt - cs_base), 32'd0);
      // trig coinciding with period expiry gives a single conversion
      step(5);
      sig_base = sig_cnt;
      trig = 1'b1;
      step(1);
      trig = 1'b0;
      chk("t4_exp_cs", 32'(adc_cs_n), 32'd0);
      wait_sig(60, ok);
      chk("t4c_sig_to", 32'(ok), 32'd1);
      chk("t4c_data",   32'(adc_data), 32'hC6);
      chk("t4c_cs_low", 32'(cs_low_cnt - cs_base), 32'd44);
      chk("t4c_sigs",   32'(sig_cnt - sig_base), 32'd1);

      // Reset in the middle of a conversion
      adc_val = 8'h77;
      wait_cs(1'b0, 40, ok);
      chk("t5_cs_to", 32'(ok), 32'd1);
      step(12);
      sig_base = sig_cnt;
      n_rst = 1'b0;
      #1;
      chk("t5_cs_n", 32'(adc_cs_n), 32'd1);
      chk("t5_sclk", 32'(adc_sclk), 32'd0);
      chk("t5_data", 32'(adc_data), 32'h00);
      chk("t5_busy", 32'(busy),     32'd0);
      step(3);
      chk("t5_no_sig", 32'(sig_cnt - sig_base), 32'd0);
      adc_val = 8'h5A;
      cs_base = cs_low_cnt;
      n_rst   = 1'b1;
      wait_sig(80, ok);
      chk("t5_sig_to", 32'(ok), 32'd1);
      chk("t5_data2",  32'(adc_data), 32'h5A);
      chk("t5_cs_low", 32'(cs_low_cnt - cs_base), 32'd44);
      en = 1'b0;
`else
      // Four conversions, one averaged result
      begin
         logic [7:0] vals [4];
         vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h41;
         en    = 1'b1;
         n_rst = 1'b1;
         for (int i = 0; i < 4; i++) begin
            adc_val = vals[i];
            wait_cs(1'b0, 60, ok);
            chk("avg_cs_lo_to", 32'(ok), 32'd1);
            wait_cs(1'b1, 60, ok);
            chk("avg_cs_hi_to", 32'(ok), 32'd1);
            if (i < 3) begin
               chk("avg_no_sig", 32'(sig), 32'd0);
               chk("avg_hold",   32'(adc_data), 32'h00);
            end else begin
               chk("avg_sig",  32'(sig), 32'd1);
               chk("avg_data", 32'(adc_data), 32'h28);
            end
         end
         step(1);
         chk("avg_sig_total", 32'(sig_cnt), 32'd1);
         en = 1'b0;
      end
`endif

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
